scpu_fetch_queue: RTL and testbench
===================================

# scpu_fetch_queue

Parametrised instruction-fetch front end for the SCPU pipeline. It replaces the fixed 8-bit PC and single IF/ID register with a PC generator, a synchronous instruction-memory request port, a DEPTH-entry prefetch queue and a valid/ready decode-side interface. It also supports branch redirect with flush. It sits between instruction memory and the ID stage / register-file read port.

## Interface
- ADDR_W, 8, PC / instruction-memory address width
- OP_W, 4, opcode field width
- REG_W, 2, register-select field width (ra, rb)
- IMM_W, 8, immediate field width
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- (derived) INSTR_W = OP_W + 2*REG_W + IMM_W; instruction layout MSB→LSB is {op, ra, rb, imm}
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous and active-low
- imem_req  out  1  fetch request this cycle
- imem_addr  out  ADDR_W  fetch address (current PC)
- imem_rdata  in  INSTR_W  instruction word; valid exactly one cycle after imem_req
- redirect_valid  in  1  branch/jump redirect
- redirect_pc  in  ADDR_W  redirect target
- id_valid  out  1  queue head valid
- id_ready  in  1  ID stage accepts head
- id_op  out  OP_W  head opcode
- id_ra  out  REG_W  head ra
- id_rb  out  REG_W  head rb
- id_imm  out  IMM_W  head immediate
- id_pc  out  ADDR_W  address the head instruction was fetched from
- count  out  $clog2(DEPTH)+1  queued entries

## Operation
- State: `pc`, `inflight` (1-bit), `inflight_pc`, queue storage with read/write pointers, and `count`.
- Pop: `pop = id_valid && id_ready`.
- Issue condition: `imem_req = rst && !redirect_valid && (count + inflight - pop < DEPTH)`.
  - Never overflows.
  - Sustains one instruction per cycle while `id_ready` is held high.
- On issue:
  - `inflight_pc <= pc`, `inflight <= 1`.
  - `pc <= pc + 1`, which wraps modulo 2^ADDR_W (0xFF → 0x00 at the default width).
- Response: in the cycle after issue, {imem_rdata, inflight_pc} is pushed at the queue tail, unless the response is killed.
- Output: id_* fields are sliced from the queue-head entry. id_* outputs are don't-care while `id_valid` = 0.
- Redirect, when `redirect_valid` = 1:
  - `pc <= redirect_pc`.
  - Queue is emptied and `count` is 0 next cycle.
  - Any response arriving next cycle is discarded.
  - No request is issued this cycle.
  - A pop in the same cycle still completes: the presented instruction counts as consumed.
  - Redirect overrides the push and issue of that cycle.
- Simultaneous push and pop: `count` is unchanged; pointers advance independently and wrap at DEPTH.
- Reset (`rst` = 0 at a clock edge):
  - pc = 0, queue empty, count = 0, inflight = 0, so id_valid = 0.
  - imem_req = 0 while rst is low.
  - Reset mid-operation discards the queue and any in-flight response.

## Timing
- Reset release at cycle 0: imem_req = 1 with addr 0 in cycle 0; data returns in cycle 1; id_valid = 1 in cycle 2. Fetch-to-decode latency is 2 cycles.
- Redirect asserted in cycle t: id_valid = 0 in cycles t+1 and t+2; request for redirect_pc in t+1; id_valid = 1 with id_pc = redirect_pc in t+3.
- Steady state with id_ready = 1: one instruction per cycle, and id_pc increments by 1 per cycle.
- With id_ready = 0: the queue fills to DEPTH, then imem_req stays 0. A fetch in flight when the queue fills is always accommodated by the issue rule.
- id_* and id_valid are driven from registered queue state only. No combinational path from imem_rdata or id_ready to id_*.
- imem_req depends combinationally on id_ready and redirect_valid.

## Structure
- Package `scpu_pkg` holds:
  - default field widths;
  - INSTR_W derivation;
  - a struct type {op, ra, rb, imm};
  - a decode function slicing an instruction word into that struct.
- One sub-module, `scpu_sync_fifo`:
  - parametrised width and depth;
  - synchronous active-low reset and a synchronous clear input (driven by redirect);
  - push/pop, count, and head data output.
- Top level holds the PC, in-flight tracking, issue logic and field decode.

## Test plan
Memory model returns instr = {addr[7:4], addr[3:2], addr[1:0], addr} one cycle after each request. All scenarios use default parameters.
- Reset then id_ready = 1 → id_valid first high 2 cycles after reset release; id_pc = 0,1,2,… on consecutive cycles; addr 0x2D gives op = 2, ra = 3, rb = 1, imm = 0x2D.
- id_ready = 0 from reset → count reaches 4; imem_req stays 0 afterwards; reasserting id_ready drains id_pc 0,1,2,3 in order with no gap before pc 4.
- Redirect to 0x80 while count = 3 and one fetch is in flight → count = 0 next cycle; next accepted id_pc = 0x80 exactly 3 cycles after redirect; no stale pc appears.
- Redirect with id_ready = 1 → the head presented in the redirect cycle is consumed; nothing else from the old stream appears.
- Redirect to 0xFE, streaming → id_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- rst = 0 mid-stream with a full queue → next cycle count = 0, id_valid = 0, imem_req = 0; after release the fetch restarts at address 0.

Source files
------------

// File: rtl/scpu_pkg.sv
// Shared widths, instruction layout and decode helper for the SCPU fetch front end.
// Instruction words are laid out MSB to LSB as {op, ra, rb, imm}.
package scpu_pkg;

    localparam int ADDR_W_DEF  = 8;
    localparam int OP_W_DEF    = 4;
    localparam int REG_W_DEF   = 2;
    localparam int IMM_W_DEF   = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int INSTR_W_DEF = OP_W_DEF + 2 * REG_W_DEF + IMM_W_DEF;

    function automatic int instr_width(input int op_w, input int reg_w, input int imm_w);
        return op_w + 2 * reg_w + imm_w;
    endfunction

    typedef struct packed {
        logic [OP_W_DEF-1:0]  op;
        logic [REG_W_DEF-1:0] ra;
        logic [REG_W_DEF-1:0] rb;
        logic [IMM_W_DEF-1:0] imm;
    } instr_t;

    function automatic instr_t decode_instr(input logic [INSTR_W_DEF-1:0] word);
        instr_t fields;
        fields.op  = word[INSTR_W_DEF-1 -: OP_W_DEF];
        fields.ra  = word[IMM_W_DEF+2*REG_W_DEF-1 -: REG_W_DEF];
        fields.rb  = word[IMM_W_DEF+REG_W_DEF-1 -: REG_W_DEF];
        fields.imm = word[IMM_W_DEF-1:0];
        return fields;
    endfunction

endpackage

// File: rtl/scpu_sync_fifo.sv
// Synchronous FIFO with registered head, occupancy count and a synchronous clear.
// Clear overrides push and pop in the same cycle.
module scpu_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_push  = push && (count_q != CNT_W'(DEPTH));
        do_pop   = pop && (count_q != '0);
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/scpu_fetch_queue.sv
// SCPU fetch front end: PC generator, one-deep imem request tracking, prefetch
// queue and valid/ready decode interface with branch redirect and flush.
module scpu_fetch_queue
    import scpu_pkg::*;
#(
    parameter  int ADDR_W  = ADDR_W_DEF,
    parameter  int OP_W    = OP_W_DEF,
    parameter  int REG_W   = REG_W_DEF,
    parameter  int IMM_W   = IMM_W_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    localparam int INSTR_W = instr_width(OP_W, REG_W, IMM_W),
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [OP_W-1:0]    id_op,
    output logic [REG_W-1:0]   id_ra,
    output logic [REG_W-1:0]   id_rb,
    output logic [IMM_W-1:0]   id_imm,
    output logic [ADDR_W-1:0]  id_pc,
    output logic [CNT_W-1:0]   count
);

    localparam int ENTRY_W = INSTR_W + ADDR_W;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic               inflight_q, inflight_d;
    logic               pop;
    logic               push;
    logic               issue;
    logic [CNT_W:0]     occupancy;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] head;
    logic [INSTR_W-1:0] head_instr;

    // Queued plus in-flight entries, after this cycle's pop, must leave room
    // for the response of anything issued now.
    always_comb begin
        pop       = (fifo_count != '0) && id_ready;
        occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q} - {{CNT_W{1'b0}}, pop};
        issue     = rst && !redirect_valid && (occupancy < (CNT_W+1)'(DEPTH));
        push      = inflight_q && !redirect_valid;

        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (redirect_valid) begin
            pc_d = redirect_pc;
        end else if (issue) begin
            pc_d          = pc_q + ADDR_W'(1);
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q          <= '0;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    scpu_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clear (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({imem_rdata, inflight_pc_q}),
        .dout  (head),
        .count (fifo_count)
    );

    assign imem_req   = issue;
    assign imem_addr  = pc_q;
    assign id_valid   = (fifo_count != '0);
    assign count      = fifo_count;
    assign id_pc      = head[ADDR_W-1:0];
    assign head_instr = head[ENTRY_W-1:ADDR_W];

    if (OP_W == OP_W_DEF && REG_W == REG_W_DEF && IMM_W == IMM_W_DEF) begin : g_pkg_decode
        instr_t fields;
        always_comb begin
            fields = decode_instr(head_instr);
            id_op  = fields.op;
            id_ra  = fields.ra;
            id_rb  = fields.rb;
            id_imm = fields.imm;
        end
    end else begin : g_slice_decode
        always_comb begin
            id_op  = head_instr[INSTR_W-1 -: OP_W];
            id_ra  = head_instr[IMM_W+2*REG_W-1 -: REG_W];
            id_rb  = head_instr[IMM_W+REG_W-1 -: REG_W];
            id_imm = head_instr[IMM_W-1:0];
        end
    end

endmodule

// File: tb/tb_scpu_fetch_queue.sv
// Scoreboard bench for scpu_fetch_queue: after each reset or redirect the decode
// side must deliver start, start+1, ... with fields derived from the address.
module tb_scpu_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [3:0]  id_op;
    logic [1:0]  id_ra;
    logic [1:0]  id_rb;
    logic [7:0]  id_imm;
    logic [7:0]  id_pc;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] gen_pc = '0;
    logic [7:0] start_pc = '0;
    bit         armed = 1'b0;
    bit         rst_low_prev = 1'b0;
    int         since = -1;

    scpu_fetch_queue dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_op          (id_op),
        .id_ra          (id_ra),
        .id_rb          (id_rb),
        .id_imm         (id_imm),
        .id_pc          (id_pc),
        .count          (count)
    );

    always #5 clk = ~clk;

    // Instruction memory: one-cycle read latency, garbage when not requested.
    always @(posedge clk) begin
        if (imem_req)
            imem_rdata <= {imem_addr[7:4], imem_addr[3:2], imem_addr[1:0], imem_addr};
        else
            imem_rdata <= 16'($urandom);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic rv, input logic [7:0] rpc, input logic rdy);
        @(posedge clk);
        #1;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
    endtask

    function automatic void modelRefill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(gen_pc);
            gen_pc = gen_pc + 8'd1;
        end
    endfunction

    function automatic void modelRestart(input logic [7:0] start);
        exp_q.delete();
        gen_pc = start;
        modelRefill();
    endfunction

    // Monitor: pops the expected stream on every accepted handshake.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!rst) begin
            checkOutput("req_during_reset", {31'd0, imem_req}, 32'd0);
            if (rst_low_prev) begin
                checkOutput("count_after_reset", {29'd0, count}, 32'd0);
                checkOutput("valid_after_reset", {31'd0, id_valid}, 32'd0);
            end
            rst_low_prev = 1'b1;
            armed        = 1'b1;
            start_pc     = 8'h00;
            since        = -1;
            modelRestart(8'h00);
        end else begin
            rst_low_prev = 1'b0;
            if (armed) begin
                since = 0;
                armed = 1'b0;
            end else if (since >= 0) begin
                since++;
            end
            if (since == 0 || since == 1) begin
                checkOutput("restart_gap", {31'd0, id_valid}, 32'd0);
            end else if (since == 2) begin
                checkOutput("restart_valid", {31'd0, id_valid}, 32'd1);
                checkOutput("restart_pc", {24'd0, id_pc}, {24'd0, start_pc});
                since = -1;
            end
            checkOutput("count_bound", {31'd0, (count <= 3'd4)}, 32'd1);
            checkOutput("valid_vs_count", {31'd0, id_valid}, {31'd0, (count != 3'd0)});
            if (redirect_valid)
                checkOutput("req_during_redirect", {31'd0, imem_req}, 32'd0);
            else if (count == 3'd4 && !id_ready)
                checkOutput("req_when_full", {31'd0, imem_req}, 32'd0);
            if (id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_pop", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("id_pc", {24'd0, id_pc}, {24'd0, e});
                    checkOutput("id_op", {28'd0, id_op}, {28'd0, e[7:4]});
                    checkOutput("id_ra", {30'd0, id_ra}, {30'd0, e[3:2]});
                    checkOutput("id_rb", {30'd0, id_rb}, {30'd0, e[1:0]});
                    checkOutput("id_imm", {24'd0, id_imm}, {24'd0, e});
                end
            end
            if (redirect_valid) begin
                modelRestart(redirect_pc);
                armed    = 1'b1;
                start_pc = redirect_pc;
                since    = -1;
            end
            modelRefill();
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset, then stream with id_ready held high.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("release_req", {31'd0, imem_req}, 32'd1);
        checkOutput("release_addr", {24'd0, imem_addr}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            checkOutput("stream_no_gap", {31'd0, id_valid}, 32'd1);
        end

        // Redirect across the address wrap, and a redirect while consuming.
        applyStimulus(1'b1, 1'b1, 8'hFE, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 1'b1, 8'h40, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

        // Fill with id_ready low, then drain with no bubble.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("fill_count", {29'd0, count}, 32'd4);
        checkOutput("fill_req", {31'd0, imem_req}, 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("drain_no_gap", {31'd0, id_valid}, 32'd1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput("drain_no_gap", {31'd0, id_valid}, 32'd1);
        end

        // Refill, then reset mid-stream with a full queue.
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("restart_req", {31'd0, imem_req}, 32'd1);
        checkOutput("restart_addr", {24'd0, imem_addr}, 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

        // Redirect while three entries are queued and one fetch is in flight.
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h80, 1'b0);
        @(negedge clk);
        checkOutput("count_before_redirect", {29'd0, count}, 32'd3);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        @(negedge clk);
        checkOutput("count_after_redirect", {29'd0, count}, 32'd0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(0, 99) != 0),
                          ($urandom_range(0, 15) == 0),
                          8'($urandom),
                          ($urandom_range(0, 3) != 0));
        end
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
